// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box tables, row-shift helpers and FSM encoding
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // out[r,c] = in[r,(c+r) mod 4]
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    // out[r,c] = in[r,(c-r+4) mod 4]
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward or inverse AES S-box lookup
module aes_sbox
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INVERSE ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/sub_shift_rows.sv
// sub_shift_rows: sequential SubBytes+ShiftRows stage; AES_SBOX_PARALLEL_EN selects 16 S-boxes and a single SUB cycle
module sub_shift_rows
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] input_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] output_state,
    output logic         busy
);

`ifdef AES_SBOX_PARALLEL_EN
    localparam int NB = 16;
`else
    localparam int NB = 4;
`endif

    fsm_t               state_q, state_d;
    aes_state_t         src_q, res_q;
    logic [8*NB-1:0]    sb_in, sb_out;
    logic               last;

`ifdef AES_SBOX_PARALLEL_EN
    assign sb_in = src_q;
    assign last  = 1'b1;
`else
    logic [1:0] col_q;
    assign sb_in = src_q[127-32*int'(col_q) -: 32];
    assign last  = col_q == 2'd3;
`endif

    for (genvar i = 0; i < NB; i++) begin : g_sbox
        aes_sbox #(.INVERSE(INVERSE)) u_sbox (
            .in_byte  (sb_in[8*i +: 8]),
            .out_byte (sb_out[8*i +: 8])
        );
    end

    // next state: accept in IDLE, substitute until the last column, hold result until taken
    always_comb begin
        state_d = state_q == IDLE ? (in_valid ? SUB : IDLE) :
                  state_q == SUB  ? (last ? DONE : SUB) :
                                    (out_ready ? IDLE : DONE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    // capture the source on acceptance and write substituted bytes during SUB
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
            res_q <= '0;
`ifndef AES_SBOX_PARALLEL_EN
            col_q <= '0;
`endif
        end else if (state_q == IDLE && in_valid) begin
            src_q <= input_state;
`ifndef AES_SBOX_PARALLEL_EN
            col_q <= '0;
`endif
        end else if (state_q == SUB) begin
`ifdef AES_SBOX_PARALLEL_EN
            res_q <= sb_out;
`else
            res_q[127-32*int'(col_q) -: 32] <= sb_out;
            col_q <= col_q + 2'd1;
`endif
        end
    end

    assign in_ready     = state_q == IDLE;
    assign out_valid    = state_q == DONE;
    assign busy         = state_q != IDLE;
    assign output_state = INVERSE ? inv_shift_rows(res_q) : shift_rows(res_q);

endmodule

// File: tb/tb_sub_shift_rows.sv
// tb_sub_shift_rows: directed and round-trip checks of forward/inverse sub_shift_rows; honours AES_SBOX_PARALLEL_EN
module tb_sub_shift_rows;

`ifdef AES_SBOX_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv   [2];
    logic         ir   [2];
    logic [127:0] ist  [2];
    logic         ov   [2];
    logic         ordy [2];
    logic [127:0] os   [2];
    logic         bsy  [2];

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] xs [100];
    int           errors = 0;
    int           checks = 0;
    int           n, sent, got;
    logic         hop;

    always #5 clk = ~clk;

    sub_shift_rows #(.INVERSE(1'b0)) u_fwd (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .input_state(ist[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .output_state(os[0]), .busy(bsy[0])
    );

    sub_shift_rows #(.INVERSE(1'b1)) u_inv (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .input_state(ist[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .output_state(os[1]), .busy(bsy[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got_v, exp_v);
        end
    endtask

    // drive one state into DUT d, push the expected result, return one step after the accepting edge
    task automatic send(input int d, input logic [127:0] x, input logic [127:0] e);
        int k = 0;
        iv[d]  = 1'b1;
        ist[d] = x;
        while (!ir[d] && k < 50) begin
            step();
            k++;
        end
        chk("send_ready", 128'(ir[d]), 128'd1);
        step();
        iv[d] = 1'b0;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic recv(input int d, input string tag);
        int k = 0;
        ordy[d] = 1'b1;
        while (!ov[d] && k < 50) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, 128'(ov[d]), 128'd1);
        chk(tag, os[d], (d == 0) ? q0.pop_front() : q1.pop_front());
        step();
        ordy[d] = 1'b0;
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [127:0] o = '0;
        logic [7:0]   m [4];
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    o[127-8*(4*c+r) -: 8] ^= gm(s[127-8*(4*c+k) -: 8], m[(k-r+4)%4]);
        return o;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ist[d] = '0; ordy[d] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 128'(ir[d]), 128'd1);
            chk("rst_out_valid", 128'(ov[d]), 128'd0);
            chk("rst_busy", 128'(bsy[d]), 128'd0);
            chk("rst_output", os[d], 128'd0);
        end

        send(0, FIPS_IN, FIPS_OUT);
        chk("fwd_busy", 128'(bsy[0]), 128'd1);
        chk("fwd_in_ready_low", 128'(ir[0]), 128'd0);
        n = 0;
        while (!ov[0] && n < 20) begin
            step();
            n++;
        end
        chk("fwd_latency", 128'(n), 128'(LAT));
        recv(0, "fips_fwd");
        chk("fwd_idle_after", 128'(ir[0]), 128'd1);

        send(1, FIPS_OUT, FIPS_IN);
        recv(1, "fips_inv");

        send(0, '0, {16{8'h63}});
        recv(0, "zero_fwd");
        send(1, '0, {16{8'h52}});
        recv(1, "zero_inv");

        send(0, FIPS_IN, FIPS_OUT);
        n = 0;
        while (!ov[0] && n < 20) begin
            step();
            n++;
        end
        chk("bp_valid", 128'(ov[0]), 128'd1);
        for (int i = 0; i < 10; i++) begin
            iv[0]  = 1'($urandom_range(0, 1));
            ist[0] = {$urandom, $urandom, $urandom, $urandom};
            chk("bp_hold", os[0], q0[0]);
            chk("bp_in_ready", 128'(ir[0]), 128'd0);
            step();
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        chk("bp_result", os[0], q0.pop_front());
        step();
        ordy[0] = 1'b0;
        chk("bp_in_ready_after", 128'(ir[0]), 128'd1);
        chk("bp_out_valid_after", 128'(ov[0]), 128'd0);

        send(0, 128'h00112233445566778899aabbccddeeff, '0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(q0.pop_back());
        chk("abort_out_valid", 128'(ov[0]), 128'd0);
        chk("abort_in_ready", 128'(ir[0]), 128'd1);
        chk("abort_output", os[0], 128'd0);
        send(0, FIPS_IN, FIPS_OUT);
        recv(0, "abort_next");

        for (int i = 0; i < 100; i++) xs[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
            iv[0]   = sent < 100;
            ist[0]  = sent < 100 ? xs[sent] : '0;
            hop     = $urandom_range(0, 3) != 0;
            iv[1]   = ov[0] && hop;
            ist[1]  = mix(mix(os[0], 1'b0), 1'b1);
            ordy[0] = ir[1] && hop;
            ordy[1] = $urandom_range(0, 2) != 0;
            if (iv[0] && ir[0]) begin
                q1.push_back(xs[sent]);
                sent++;
            end
            if (ov[1] && ordy[1]) begin
                chk("chain", os[1], q1.pop_front());
                got++;
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0;
        end
        chk("chain_count", 128'(got), 128'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
